ifu: RTL and testbench

Instruction fetch unit and PC owner for the multi-cycle npc core. It sits at the opposite end of the execute unit's branch interface. It fetches one instruction at a time from instruction memory and hands it to decode over a valid/ready handshake. It then waits for the execute unit to resolve the instruction, and consumes that unit's `PCAsrc`/`PCBsrc` selects to form and register the next PC.

---
 rtl/ifu.sv | 93 +++++++++
 tb/tb_ifu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time,
// hands it to decode, then forms the next PC from the execute unit's selects.
module ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCAsrc,
    input  logic            PCBsrc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            ex_valid,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;

    logic [XLEN-1:0] w_addend_a;
    logic [XLEN-1:0] w_addend_b;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_next_pc;
    logic            w_req_accept;
    logic            w_inst_accept;
    logic            w_ex_fire;

    // JALR targets drop bit 0; branch/JAL/sequential sums pass through untouched.
    assign w_addend_a = PCAsrc ? imm : PC_STEP;
    assign w_addend_b = PCBsrc ? rs1 : r_pc;
    assign w_sum      = w_addend_a + w_addend_b;
    assign w_next_pc  = PCBsrc ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

    assign w_req_accept  = (r_state == S_REQ)  && imem_req_ready;
    assign w_inst_accept = (r_state == S_HOLD) && inst_ready;
    assign w_ex_fire     = (r_state == S_EXEC) && ex_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_req_accept) r_state <= S_WAIT;
                end
                // A response coinciding with acceptance is dropped; only WAIT listens.
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_inst  <= imem_rsp_data;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_inst_accept) r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_ex_fire) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign inst_valid     = (r_state == S_HOLD);
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign inst           = r_inst;

endmodule

// File: tb/tb_ifu.sv
// Randomized self-checking bench for ifu: drives memory, decode and execute
// peers and compares against an arithmetic next-PC model.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCAsrc = 1'b0;
    logic        PCBsrc = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic        ex_valid = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] m_pc = 32'h8000_0000;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .PCAsrc(PCAsrc), .PCBsrc(PCBsrc), .imm(imm), .rs1(rs1), .ex_valid(ex_valid),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Next PC from the rules: wide sum, reduce modulo 2^32, JALR forces an even target.
    function automatic logic [31:0] model_next(input bit a, input bit b, input logic [31:0] pcv,
                                               input logic [31:0] immv, input logic [31:0] rs1v);
        longint unsigned s;
        s = 64'(a ? immv : 32'd4) + 64'(b ? rs1v : pcv);
        s = s % 64'h1_0000_0000;
        if (b) s = s - (s % 2);
        return s[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [31:0] data, input int rq_w, input int rs_w,
                            input int hd_w, input int ex_w, input bit asrc, input bit bsrc,
                            input logic [31:0] immv, input logic [31:0] rs1v, input bit spur,
                            output int acc);
        int n;
        n = 0;
        acc = -1;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: imem_req_valid=%b required 1", imem_req_valid);
            return;
        end
        checks++;
        if (imem_addr !== m_pc) begin
            errors++;
            $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, m_pc);
        end
        for (int i = 0; i < rq_w; i++) begin
            imem_req_ready = 1'b0;
            if (spur && i == 0) imem_rsp_valid = 1'b1;
            step();
            imem_rsp_valid = 1'b0;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_hold: valid=%b addr=%h pc=%h inst_valid=%b required 1/%h/%h/0",
                         imem_req_valid, imem_addr, pc, inst_valid, m_pc, m_pc);
            end
        end
        imem_req_ready = 1'b1;
        acc = cyc;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_dup: imem_req_valid=%b inst_valid=%b required 0/0", imem_req_valid, inst_valid);
        end
        for (int i = 0; i < rs_w; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_idle: imem_req_valid=%b inst_valid=%b required 0/0", imem_req_valid, inst_valid);
            end
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        checks++;
        if (inst_valid !== 1'b1 || inst !== data || pc !== m_pc) begin
            errors++;
            $display("FAIL hold_entry: inst_valid=%b inst=%h pc=%h required 1/%h/%h", inst_valid, inst, pc, data, m_pc);
        end
        for (int i = 0; i < hd_w; i++) begin
            inst_ready = 1'b0;
            if (spur && i == 0) begin
                ex_valid = 1'b1;
                PCAsrc   = 1'b1;
                PCBsrc   = 1'($urandom);
                imm      = $urandom;
            end
            step();
            ex_valid = 1'b0;
            checks++;
            if (inst_valid !== 1'b1 || inst !== data || pc !== m_pc || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: inst_valid=%b inst=%h pc=%h req=%b required 1/%h/%h/0",
                         inst_valid, inst, pc, imem_req_valid, data, m_pc);
            end
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== m_pc || inst !== data) begin
            errors++;
            $display("FAIL exec_entry: inst_valid=%b req=%b pc=%h inst=%h required 0/0/%h/%h",
                     inst_valid, imem_req_valid, pc, inst, m_pc, data);
        end
        for (int i = 0; i < ex_w; i++) begin
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || pc !== m_pc || inst !== data) begin
                errors++;
                $display("FAIL exec_wait: req=%b pc=%h inst=%h required 0/%h/%h", imem_req_valid, pc, inst, m_pc, data);
            end
        end
        ex_valid = 1'b1;
        PCAsrc   = asrc;
        PCBsrc   = bsrc;
        imm      = immv;
        rs1      = rs1v;
        m_pc     = model_next(asrc, bsrc, m_pc, immv, rs1v);
        step();
        ex_valid = 1'b0;
        PCAsrc   = 1'($urandom);
        PCBsrc   = 1'($urandom);
        imm      = $urandom;
        rs1      = $urandom;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== m_pc || pc !== m_pc) begin
            errors++;
            $display("FAIL next_pc: req=%b addr=%h pc=%h required 1/%h/%h", imem_req_valid, imem_addr, pc, m_pc, m_pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        m_pc = RST_PC;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RST_PC || imem_addr !== RST_PC || inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b inst_valid=%b pc=%h addr=%h inst=%h required 0/0/%h/%h/0",
                     imem_req_valid, inst_valid, pc, imem_addr, inst, RST_PC, RST_PC);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1/%h", imem_req_valid, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        int a0, a1, a2;
        do_instr(32'h0000_0013, 0, 0, 0, 0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, a0);
        checks++;
        if (pc !== 32'h8000_0004) begin
            errors++;
            $display("FAIL seq_pc1: pc=%h required 80000004", pc);
        end
        do_instr(32'h0000_0013, 0, 0, 0, 0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, a1);
        do_instr(32'h0000_0013, 0, 0, 0, 0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, a2);
        checks++;
        if (a1 - a0 != 4 || a2 - a1 != 4) begin
            errors++;
            $display("FAIL loop_len: cycles=%0d,%0d required 4,4", a1 - a0, a2 - a1);
        end
        checks++;
        if (pc !== 32'h8000_000C) begin
            errors++;
            $display("FAIL seq_pc3: pc=%h required 8000000c", pc);
        end
    endtask

    task automatic test_branch();
        int a;
        do_instr($urandom, 0, 0, 0, 0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, a);
        checks++;
        if (pc !== 32'h8000_0010) begin
            errors++;
            $display("FAIL branch_setup: pc=%h required 80000010", pc);
        end
        do_instr($urandom, 0, 0, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFF0, $urandom, 1'b0, a);
        checks++;
        if (imem_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL branch_target: addr=%h required 80000000", imem_addr);
        end
    endtask

    task automatic test_jalr();
        int a;
        do_instr($urandom, 0, 0, 0, 0, 1'b1, 1'b1, 32'h4, 32'h8000_1001, 1'b0, a);
        checks++;
        if (imem_addr !== 32'h8000_1004) begin
            errors++;
            $display("FAIL jalr_target: addr=%h required 80001004", imem_addr);
        end
        do_instr($urandom, 0, 0, 0, 0, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFC, 1'b0, a);
        checks++;
        if (imem_addr !== 32'h0000_0004) begin
            errors++;
            $display("FAIL jalr_wrap: addr=%h required 00000004", imem_addr);
        end
    endtask

    task automatic test_backpressure();
        int a;
        do_instr($urandom, 3, 1, 5, 1, 1'b0, 1'b0, $urandom, $urandom, 1'b0, a);
        do_instr($urandom, 3, 2, 5, 2, 1'b1, 1'b0, 32'h0000_0100, $urandom, 1'b0, a);
    endtask

    task automatic test_spurious();
        int a;
        do_instr($urandom, 2, 0, 2, 0, 1'b0, 1'b0, $urandom, $urandom, 1'b1, a);
        do_instr($urandom, 1, 1, 1, 1, 1'b0, 1'b1, $urandom, 32'h8000_0200, 1'b1, a);
    endtask

    task automatic test_reset_mid();
        int a;
        do_instr($urandom, 0, 0, 0, 0, 1'b1, 1'b1, 32'h0, 32'h8000_0040, 1'b0, a);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if (pc !== 32'h8000_0040 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup: pc=%h req=%b inst_valid=%b required 80000040/0/0", pc, imem_req_valid, inst_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_pc = RST_PC;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RST_PC || inst !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: req=%b inst_valid=%b pc=%h inst=%h required 0/0/%h/0",
                     imem_req_valid, inst_valid, pc, inst, RST_PC);
        end
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL mid_refetch: req=%b addr=%h required 1/%h", imem_req_valid, imem_addr, RST_PC);
        end
        do_instr($urandom, 0, 0, 0, 0, 1'b0, 1'b0, $urandom, $urandom, 1'b0, a);
    endtask

    task automatic test_random();
        int a;
        for (int k = 0; k < 40; k++) begin
            do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom, $urandom,
                     1'($urandom), a);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
